// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit multi-cycle core: opcodes, sequencer
// states and instruction field helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_MOVL = 4'h8;
    localparam logic [3:0] OP_MOVH = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_MEM  = 4'hF;

    localparam logic [3:0] X_JZ  = 4'h0;
    localparam logic [3:0] X_JNZ = 4'h1;
    localparam logic [3:0] X_JS  = 4'h2;
    localparam logic [3:0] X_JNS = 4'h3;
    localparam logic [3:0] X_LD  = 4'h0;
    localparam logic [3:0] X_ST  = 4'h1;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rt;
    } insn_t;

    function automatic logic [7:0] imm8(insn_t i);
        return {i.ra, i.rb};
    endfunction

    // sub reads rb on port 1; everything else that needs it reads rt
    function automatic logic [3:0] port1_addr(insn_t i);
        return (i.op == OP_SUB) ? i.rb : i.rt;
    endfunction

    function automatic logic is_defined(insn_t i);
        logic ok;
        ok = 1'b0;
        case (i.op)
            OP_SUB, OP_MOVL, OP_MOVH: ok = 1'b1;
            OP_JMP:                   ok = (i.rb[3:2] == 2'b00);
            OP_MEM:                   ok = (i.rb[3:1] == 3'b000);
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath: sub/movl/movh result and branch condition.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [3:0]  i_xop,
    input  logic [7:0]  i_imm8,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_result,
    output logic        o_taken
);

    always_comb begin
        o_result = '0;
        unique case (1'b1)
            (i_op == OP_SUB):  o_result = i_a - i_b;
            (i_op == OP_MOVL): o_result = {{8{i_imm8[7]}}, i_imm8};
            (i_op == OP_MOVH): o_result = {i_imm8, i_b[7:0]};
            default:           o_result = '0;
        endcase
    end

    always_comb begin
        o_taken = 1'b0;
        case (i_xop)
            X_JZ:    o_taken = (i_a == 16'h0000);
            X_JNZ:   o_taken = (i_a != 16'h0000);
            X_JS:    o_taken = i_a[15];
            X_JNS:   o_taken = ~i_a[15];
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle sequencer: owns PC, drives memory and register-file
// ports, prints on r0 writes and halts on undefined opcodes.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [14:0] mem_raddr0,
    input  logic [15:0] mem_rdata0,
    output logic [14:0] mem_raddr1,
    input  logic [15:0] mem_rdata1,
    output logic        mem_wen,
    output logic [14:0] mem_waddr,
    output logic [15:0] mem_wdata,
    output logic [3:0]  reg_raddr0,
    output logic [3:0]  reg_raddr1,
    input  logic [15:0] reg_rdata0,
    input  logic [15:0] reg_rdata1,
    output logic        reg_wen,
    output logic [3:0]  reg_waddr,
    output logic [15:0] reg_wdata,
    output logic        print_valid,
    output logic [7:0]  print_char,
    output logic        halted,
    output logic [15:0] pc,
    output logic [31:0] retired
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] w_pc_inc;
    insn_t       r_ir;
    insn_t       w_dec;
    logic        r_halted;
    logic [31:0] r_retired;
    logic        w_retire;
    logic        w_halt;
    logic        w_wr;
    logic [15:0] w_wr_data;
    logic [3:0]  w_p1;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_result;
    logic        w_taken;
    logic        w_defined;
    logic        w_is_jmp;
    logic        w_is_ld;
    logic        w_is_st;

    assign w_dec     = insn_t'(mem_rdata0);
    assign w_p1      = port1_addr(r_ir);
    assign w_a       = (r_ir.ra == 4'd0) ? 16'h0000 : reg_rdata0;
    assign w_b       = (w_p1 == 4'd0) ? 16'h0000 : reg_rdata1;
    assign w_pc_inc  = r_pc + 16'd2;
    assign w_defined = is_defined(r_ir);
    assign w_is_jmp  = w_defined && (r_ir.op == OP_JMP);
    assign w_is_ld   = w_defined && (r_ir.op == OP_MEM) && (r_ir.rb == X_LD);
    assign w_is_st   = w_defined && (r_ir.op == OP_MEM) && (r_ir.rb == X_ST);

    cpu_alu u_alu (
        .i_op     (r_ir.op),
        .i_xop    (r_ir.rb),
        .i_imm8   (imm8(r_ir)),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_result),
        .o_taken  (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (r_state == S_DECODE) r_ir <= w_dec;
            if (w_halt) r_halted <= 1'b1;
            if (w_retire) r_retired <= r_retired + 32'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_retire   = 1'b0;
        w_halt     = 1'b0;
        w_wr       = 1'b0;
        w_wr_data  = '0;
        mem_raddr1 = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        reg_raddr0 = '0;
        reg_raddr1 = '0;
        case (r_state)
            S_FETCH: begin
                if (run) w_next = S_DECODE;
            end
            S_DECODE: begin
                reg_raddr0 = w_dec.ra;
                reg_raddr1 = port1_addr(w_dec);
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                unique case (1'b1)
                    !w_defined: begin
                        w_halt = 1'b1;
                        w_next = S_HALT;
                    end
                    w_is_ld: begin
                        mem_raddr1 = w_a[15:1];
                        w_next     = S_MEM;
                    end
                    w_is_st: begin
                        mem_wen   = 1'b1;
                        mem_waddr = w_a[15:1];
                        mem_wdata = w_b;
                        w_retire  = 1'b1;
                        w_pc_next = w_pc_inc;
                    end
                    w_is_jmp: begin
                        w_retire  = 1'b1;
                        w_pc_next = w_taken ? (w_b & 16'hFFFE) : w_pc_inc;
                    end
                    default: begin
                        w_wr      = 1'b1;
                        w_wr_data = w_result;
                        w_retire  = 1'b1;
                        w_pc_next = w_pc_inc;
                    end
                endcase
            end
            S_MEM: begin
                w_wr      = 1'b1;
                w_wr_data = mem_rdata1;
                w_retire  = 1'b1;
                w_pc_next = w_pc_inc;
                w_next    = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // r0 is not stored: a write to it becomes a console character
    assign reg_wen     = w_wr && (r_ir.rt != 4'd0);
    assign print_valid = w_wr && (r_ir.rt == 4'd0);
    assign reg_waddr   = w_wr ? r_ir.rt : 4'd0;
    assign reg_wdata   = w_wr_data;
    assign print_char  = w_wr_data[7:0];

    assign mem_raddr0 = r_pc[15:1];
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: an instruction-level model predicts
// every write, print and retirement; a monitor checks them in order.
module tb_cpu_ctrl;

    localparam int K_REG = 0;
    localparam int K_PRN = 1;
    localparam int K_MEM = 2;
    localparam int K_RET = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [14:0] mem_raddr0, mem_raddr1, mem_waddr;
    logic [15:0] mem_rdata0, mem_rdata1, mem_wdata;
    logic        mem_wen;
    logic [3:0]  reg_raddr0, reg_raddr1, reg_waddr;
    logic [15:0] reg_rdata0, reg_rdata1, reg_wdata;
    logic        reg_wen, print_valid, halted;
    logic [7:0]  print_char;
    logic [15:0] pc;
    logic [31:0] retired;

    cpu_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_raddr0(mem_raddr0), .mem_rdata0(mem_rdata0),
        .mem_raddr1(mem_raddr1), .mem_rdata1(mem_rdata1),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .reg_raddr0(reg_raddr0), .reg_raddr1(reg_raddr1),
        .reg_rdata0(reg_rdata0), .reg_rdata1(reg_rdata1),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .print_valid(print_valid), .print_char(print_char),
        .halted(halted), .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    // environment: synchronous-read memory and register file
    logic [15:0] tb_mem [0:32767];
    logic [15:0] tb_rf  [0:15];
    always @(posedge clk) begin
        mem_rdata0 <= tb_mem[mem_raddr0];
        mem_rdata1 <= tb_mem[mem_raddr1];
        reg_rdata0 <= tb_rf[reg_raddr0];
        reg_rdata1 <= tb_rf[reg_raddr1];
        if (mem_wen) tb_mem[mem_waddr] <= mem_wdata;
        if (reg_wen) tb_rf[reg_waddr] <= reg_wdata;
    end

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ret = -1;
    logic [31:0] prev_ret = '0;
    bit no_lat = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic pop_chk(int kind, logic [31:0] a, logic [31:0] d, string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event a=%h d=%h", name, a, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.a !== a || e.d !== d) begin
            errors++;
            $display("FAIL %s: got kind %0d a=%h d=%h want kind %0d a=%h d=%h",
                     name, kind, a, d, e.kind, e.a, e.d);
        end
        if (kind == K_RET && e.lat != 0 && last_ret >= 0)
            chk("latency", 32'(cyc - last_ret), 32'(e.lat));
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_ret = '0;
            last_ret = -1;
        end else begin
            if (reg_wen) pop_chk(K_REG, 32'(reg_waddr), 32'(reg_wdata), "regwr");
            if (print_valid) pop_chk(K_PRN, 32'd0, 32'(print_char), "print");
            if (mem_wen) pop_chk(K_MEM, 32'(mem_waddr), 32'(mem_wdata), "memwr");
            if (retired != prev_ret) begin
                pop_chk(K_RET, 32'(pc), retired, "retire");
                prev_ret = retired;
                last_ret = cyc;
            end
        end
    end

    // instruction-level reference model
    logic [15:0] iss_mem [0:32767];
    logic [15:0] iss_rf  [0:15];
    logic [15:0] iss_pc;
    int          iss_ret;
    bit          iss_halted;

    task automatic push(int k, logic [31:0] a, logic [31:0] d, int lat);
        exp_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] rd(logic [3:0] r);
        return (r == 4'd0) ? 16'h0000 : iss_rf[r];
    endfunction

    task automatic iss_wr(logic [3:0] r, logic [15:0] v);
        if (r == 4'd0) begin
            push(K_PRN, 32'd0, 32'(v % 16'd256), 0);
        end else begin
            push(K_REG, 32'(r), 32'(v), 0);
            iss_rf[r] = v;
        end
    endtask

    task automatic iss_step();
        logic [15:0] w, a, t, npc;
        logic [3:0]  op, ra, x, rt;
        logic [7:0]  imm;
        bit          ok, tk;
        int          lat;
        w   = iss_mem[iss_pc[15:1]];
        op  = w[15:12];
        ra  = w[11:8];
        x   = w[7:4];
        rt  = w[3:0];
        imm = w[11:4];
        a   = rd(ra);
        npc = iss_pc + 16'd2;
        ok  = 1'b1;
        lat = 3;
        if (op == 4'h0) begin
            iss_wr(rt, a - rd(x));
        end else if (op == 4'h8) begin
            t = 16'(imm);
            if (imm >= 8'd128) t = t - 16'd256;
            iss_wr(rt, t);
        end else if (op == 4'h9) begin
            iss_wr(rt, 16'(imm) * 16'd256 + rd(rt) % 16'd256);
        end else if (op == 4'hE && x < 4'd4) begin
            tk = (x == 4'd0) ? (a == 16'd0) :
                 (x == 4'd1) ? (a != 16'd0) :
                 (x == 4'd2) ? (a >= 16'h8000) : (a < 16'h8000);
            if (tk) npc = (rd(rt) / 16'd2) * 16'd2;
        end else if (op == 4'hF && x == 4'd0) begin
            iss_wr(rt, iss_mem[a[15:1]]);
            lat = 4;
        end else if (op == 4'hF && x == 4'd1) begin
            push(K_MEM, 32'(a / 16'd2), 32'(rd(rt)), 0);
            iss_mem[a[15:1]] = rd(rt);
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            iss_halted = 1'b1;
        end else begin
            iss_pc = npc;
            iss_ret++;
            push(K_RET, 32'(iss_pc), 32'(iss_ret), no_lat ? 0 : lat);
        end
    endtask

    task automatic put(int w, logic [15:0] v);
        tb_mem[w] <= v;
        iss_mem[w] = v;
    endtask

    task automatic init_state(bit rnd_code);
        logic [15:0] v;
        for (int i = 0; i < 32768; i++) put(i, rnd_code ? rnd_insn() : 16'h2000);
        for (int r = 0; r < 16; r++) begin
            v = 16'($urandom);
            tb_rf[r] <= (r == 0) ? 16'hDEAD : v;
            iss_rf[r] = v;
        end
        iss_pc     = 16'h0000;
        iss_ret    = 0;
        iss_halted = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [15:0] rnd_insn();
        int p;
        logic [15:0] w;
        p = $urandom_range(99);
        w = 16'($urandom);
        if (p < 25) w[15:12] = 4'h0;
        else if (p < 45) w[15:12] = 4'h8;
        else if (p < 60) w[15:12] = 4'h9;
        else if (p < 78) begin
            w[15:12] = 4'hE;
            w[7:4] = 4'($urandom_range(3));
        end else if (p < 97) begin
            w[15:12] = 4'hF;
            w[7:4] = 4'($urandom_range(1));
        end else w[15:12] = 4'h3;
        return w;
    endfunction

    task automatic reset_core();
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_prog(int k, string tag);
        int target;
        bit done;
        done = 1'b0;
        for (int n = 0; n < k && !iss_halted; n++) iss_step();
        target = iss_ret;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        for (int c = 0; c < 6 * k + 40 && !done; c++) begin
            @(negedge clk);
            if (!iss_halted && retired == 32'(target)) begin
                run = 1'b0;
                done = 1'b1;
            end
            if (iss_halted && halted) done = 1'b1;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: retired %0d want %0d", tag, retired, target);
        end
        repeat (8) @(negedge clk);
        chk({tag, " pc"}, 32'(pc), 32'(iss_pc));
        chk({tag, " halted"}, 32'(halted), 32'(iss_halted));
        chk({tag, " retired"}, retired, 32'(iss_ret));
        chk({tag, " drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst pc", 32'(pc), 32'h0);
        chk("rst halted", 32'(halted), 32'h0);
        chk("rst retired", retired, 32'h0);
        chk("rst wens", 32'({mem_wen, reg_wen, print_valid}), 32'h0);
        chk("rst raddr1", 32'(mem_raddr1), 32'h0);
        chk("rst regaddr", 32'({reg_raddr0, reg_raddr1}), 32'h0);

        // directed program: print, movl/movh, jumps, st/ld, js, halt
        reset_core();
        init_state(1'b0);
        put(0, 16'h8411); put(1, 16'h0100); put(2, 16'h8FF2);
        put(3, 16'h9122); put(4, 16'h8803); put(5, 16'h8105);
        put(6, 16'h8004); put(7, 16'hE405); put(8, 16'hE415);
        put(9, 16'h8346); put(10, 16'h9126); put(11, 16'h8708);
        put(12, 16'hF816); put(13, 16'hF807); put(14, 16'h0700);
        put(15, 16'h8009); put(16, 16'h9809); put(17, 16'h840A);
        put(18, 16'hE92A);
        run_prog(40, "dir");
        chk("dir final pc", 32'(pc), 32'h0040);
        chk("dir count", retired, 32'd19);
        chk("dir r2", 32'(tb_rf[2]), 32'h12FF);
        chk("dir r3", 32'(tb_rf[3]), 32'hFF80);
        chk("dir r7", 32'(tb_rf[7]), 32'h1234);
        chk("dir mem", 32'(tb_mem[16'h38]), 32'h1234);

        // undefined opcode at 0x0006
        reset_core();
        init_state(1'b0);
        put(0, 16'h8011); put(1, 16'h8022); put(2, 16'h8033); put(3, 16'h2123);
        run_prog(10, "halt");
        chk("halt pc", 32'(pc), 32'h0006);
        chk("halt flag", 32'(halted), 32'h1);

        // PC wrap from 0xFFFE
        reset_core();
        init_state(1'b0);
        put(0, 16'h8FE1); put(1, 16'hE001); put(32767, 16'h8052);
        run_prog(3, "wrap");
        chk("wrap pc", 32'(pc), 32'h0000);
        chk("wrap r2", 32'(tb_rf[2]), 32'h0005);

        // run dropped while in DECODE
        reset_core();
        init_state(1'b0);
        put(0, 16'h8411);
        no_lat = 1'b1;
        iss_step();
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (10) @(negedge clk);
        chk("run0 retired", retired, 32'd1);
        chk("run0 pc", 32'(pc), 32'h0002);
        chk("run0 drain", 32'(exp_q.size()), 32'd0);
        no_lat = 1'b0;

        // reset while a store is in EXEC
        reset_core();
        init_state(1'b0);
        put(0, 16'hF112);
        put(16'h80, 16'h0000);
        tb_rf[1] <= 16'h0100;
        tb_rf[2] <= 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("exec wen", 32'(mem_wen), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst wen", 32'(mem_wen), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst nowrite", 32'(tb_mem[16'h80]), 32'h0);
        chk("rst mid pc", 32'(pc), 32'h0);
        chk("rst mid ret", retired, 32'h0);

        // random programs over the whole memory
        for (int p = 0; p < 8; p++) begin
            reset_core();
            init_state(1'b1);
            run_prog(150, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
